// File: rtl/bp_tlb_event_monitor_pkg.sv
// bp_common_pkg: shared selector and FSM types for the TLB event monitor
package bp_common_pkg;
   localparam int tlb_stat_sel_width_gp = 3;
   localparam int tlb_stat_num_gp = 7;
   typedef enum logic [tlb_stat_sel_width_gp-1:0] {
      e_tlb_stat_reads,
      e_tlb_stat_misses,
      e_tlb_stat_fills,
      e_tlb_stat_clears,
      e_tlb_stat_lat_sum,
      e_tlb_stat_lat_max,
      e_tlb_stat_aborts
   } bp_tlb_stat_sel_e;
   typedef enum logic {e_lat_idle, e_lat_wait} bp_tlb_lat_state_e;
endpackage

// File: rtl/bp_tlb_event_monitor_channel.sv
// bp_tlb_event_channel: one TLB's saturating event counters and miss-to-fill latency tracker
module bp_tlb_event_channel
   import bp_common_pkg::*;
#(
   parameter int cnt_width_p = 32,
   parameter int lat_width_p = 16
)(
   input  logic                                        clk_i,
   input  logic                                        reset_n_i,
   input  logic                                        freeze_i,
   input  logic                                        clr_stats_i,
   input  logic                                        cam_r_v_i,
   input  logic                                        miss_v_i,
   input  logic                                        fill_v_i,
   input  logic                                        clear_i,
   output logic [tlb_stat_num_gp-1:0][cnt_width_p-1:0] stat_o
);
   localparam int sum_width_lp = (cnt_width_p > lat_width_p ? cnt_width_p : lat_width_p) + 1;
   bp_tlb_lat_state_e state_q, state_d;
   logic [4:0][cnt_width_p-1:0] cnt_q, cnt_d;
   logic [4:0] inc;
   logic [cnt_width_p-1:0] lat_sum_q, lat_sum_d;
   logic [lat_width_p-1:0] lat_q, lat_d, lat_max_q, lat_max_d;
   logic [sum_width_lp-1:0] sum_ext;
   logic in_wait, done, abort;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) state_q <= e_lat_idle;
      else state_q <= state_d;
   always_comb
      state_d = (clr_stats_i | freeze_i) ? e_lat_idle
              : (state_q == e_lat_idle) ? ((miss_v_i & ~fill_v_i) ? e_lat_wait : e_lat_idle)
              : ((fill_v_i | clear_i) ? e_lat_idle : e_lat_wait);
   always_comb begin
      in_wait = (state_q == e_lat_wait) & ~freeze_i;
      done = in_wait & fill_v_i & ~clear_i;
      abort = in_wait & clear_i;
      lat_d = (state_d != e_lat_wait) ? '0
            : (state_q == e_lat_idle) ? lat_width_p'(1)
            : (&lat_q ? lat_q : lat_q + 1'b1);
      inc = freeze_i ? '0 : {abort, clear_i, fill_v_i, miss_v_i, cam_r_v_i};
   end
   always_comb begin
      sum_ext = sum_width_lp'(lat_sum_q) + sum_width_lp'(lat_q);
      for (int i = 0; i < 5; i++)
         cnt_d[i] = clr_stats_i ? '0 : (inc[i] & ~&cnt_q[i]) ? cnt_q[i] + 1'b1 : cnt_q[i];
      lat_sum_d = clr_stats_i ? '0
                : ~done ? lat_sum_q
                : (sum_ext > sum_width_lp'({cnt_width_p{1'b1}})) ? '1 : cnt_width_p'(sum_ext);
      lat_max_d = clr_stats_i ? '0 : (done & (lat_q > lat_max_q)) ? lat_q : lat_max_q;
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         cnt_q <= '0;
         lat_sum_q <= '0;
         lat_q <= '0;
         lat_max_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lat_sum_q <= lat_sum_d;
         lat_q <= lat_d;
         lat_max_q <= lat_max_d;
      end
   assign stat_o = {cnt_q[4], cnt_width_p'(lat_max_q), lat_sum_q, cnt_q[3:0]};
endmodule

// File: rtl/bp_tlb_event_monitor.sv
// bp_tlb_event_monitor: per-TLB event statistics with a valid/yumi readout register
module bp_tlb_event_monitor
   import bp_common_pkg::*;
#(
   parameter int num_tlb_p = 2,
   parameter int cnt_width_p = 32,
   parameter int lat_width_p = 16,
   localparam int tlb_width_lp = (num_tlb_p > 1) ? $clog2(num_tlb_p) : 1
)(
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic                             freeze_i,
   input  logic                             clr_stats_i,
   input  logic [num_tlb_p-1:0]             cam_r_v_i,
   input  logic [num_tlb_p-1:0]             miss_v_i,
   input  logic [num_tlb_p-1:0]             fill_v_i,
   input  logic [num_tlb_p-1:0]             clear_i,
   input  logic                             rd_v_i,
   output logic                             rd_ready_o,
   input  logic [tlb_width_lp-1:0]          rd_tlb_i,
   input  logic [tlb_stat_sel_width_gp-1:0] rd_sel_i,
   output logic                             data_v_o,
   output logic [cnt_width_p-1:0]           data_o,
   input  logic                             data_yumi_i
);
   logic [num_tlb_p-1:0][tlb_stat_num_gp-1:0][cnt_width_p-1:0] stats;
   logic [cnt_width_p-1:0] sel_data, data_q, data_d;
   logic data_v_q, data_v_d, accept;
   for (genvar i = 0; i < num_tlb_p; i++) begin : ch
      bp_tlb_event_channel #(.cnt_width_p(cnt_width_p), .lat_width_p(lat_width_p)) chan (
         .clk_i(clk_i),
         .reset_n_i(reset_n_i),
         .freeze_i(freeze_i),
         .clr_stats_i(clr_stats_i),
         .cam_r_v_i(cam_r_v_i[i]),
         .miss_v_i(miss_v_i[i]),
         .fill_v_i(fill_v_i[i]),
         .clear_i(clear_i[i]),
         .stat_o(stats[i])
      );
   end
   always_comb begin
      sel_data = (int'(rd_tlb_i) < num_tlb_p && int'(rd_sel_i) < tlb_stat_num_gp)
               ? stats[rd_tlb_i][rd_sel_i] : '0;
      rd_ready_o = ~data_v_q | data_yumi_i;
      accept = rd_v_i & rd_ready_o;
      data_v_d = accept | (data_v_q & ~data_yumi_i);
      data_d = accept ? sel_data : data_q;
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         data_v_q <= 1'b0;
         data_q <= '0;
      end else begin
         data_v_q <= data_v_d;
         data_q <= data_d;
      end
   assign data_v_o = data_v_q;
   assign data_o = data_q;
   assert property (@(posedge clk_i) disable iff (!reset_n_i) data_yumi_i |-> data_v_q);
endmodule

// File: tb/tb_bp_tlb_event_monitor.sv
// tb_bp_tlb_event_monitor: directed and random checks against a timestamp-based statistics model
module tb_bp_tlb_event_monitor;
   import bp_common_pkg::*;
   localparam int n_lp = 2;
   localparam longint cmax_lp = 64'hFFFF_FFFF;
   localparam longint lmax_lp = 65535;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n, freeze, clr_stats, rd_v, rd_ready, data_v, data_yumi;
   logic [n_lp-1:0] cam, miss, fill, clr_ch;
   logic [0:0] rd_tlb;
   logic [2:0] rd_sel;
   logic [31:0] data;
   logic freeze_s, clr_s, rd_v_s, rd_ready_s, data_v_s, yumi_s;
   logic [0:0] cam_s, rd_tlb_s;
   logic [2:0] rd_sel_s;
   logic [3:0] data_s;
   int n_assert = 0, n_fail = 0;
   longint m [n_lp][7];
   bit pend [n_lp];
   longint start [n_lp];
   longint cyc = 0;

   bp_tlb_event_monitor #(.num_tlb_p(n_lp), .cnt_width_p(32), .lat_width_p(16)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .clr_stats_i(clr_stats),
      .cam_r_v_i(cam), .miss_v_i(miss), .fill_v_i(fill), .clear_i(clr_ch),
      .rd_v_i(rd_v), .rd_ready_o(rd_ready), .rd_tlb_i(rd_tlb), .rd_sel_i(rd_sel),
      .data_v_o(data_v), .data_o(data), .data_yumi_i(data_yumi));

   bp_tlb_event_monitor #(.num_tlb_p(1), .cnt_width_p(4), .lat_width_p(4)) dut_s (
      .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze_s), .clr_stats_i(clr_s),
      .cam_r_v_i(cam_s), .miss_v_i(1'b0), .fill_v_i(1'b0), .clear_i(1'b0),
      .rd_v_i(rd_v_s), .rd_ready_o(rd_ready_s), .rd_tlb_i(rd_tlb_s), .rd_sel_i(rd_sel_s),
      .data_v_o(data_v_s), .data_o(data_s), .data_yumi_i(yumi_s));

   function automatic longint sat(longint v, longint mx);
      return v > mx ? mx : v;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < n_lp; c++) begin
         pend[c] = 0;
         for (int s = 0; s < 7; s++) m[c][s] = 0;
      end
   endtask

   // Latency is the cycle distance between the miss edge and the fill edge.
   task automatic model_edge();
      longint l;
      cyc++;
      if (!reset_n || clr_stats) begin
         model_clear();
         return;
      end
      for (int c = 0; c < n_lp; c++) begin
         if (freeze) begin
            pend[c] = 0;
            continue;
         end
         m[c][0] = sat(m[c][0] + longint'(cam[c]), cmax_lp);
         m[c][1] = sat(m[c][1] + longint'(miss[c]), cmax_lp);
         m[c][2] = sat(m[c][2] + longint'(fill[c]), cmax_lp);
         m[c][3] = sat(m[c][3] + longint'(clr_ch[c]), cmax_lp);
         if (pend[c]) begin
            l = sat(cyc - start[c], lmax_lp);
            if (clr_ch[c]) begin
               m[c][6] = sat(m[c][6] + 1, cmax_lp);
               pend[c] = 0;
            end else if (fill[c]) begin
               m[c][4] = sat(m[c][4] + l, cmax_lp);
               if (l > m[c][5]) m[c][5] = l;
               pend[c] = 0;
            end
         end else if (miss[c] && !fill[c]) begin
            pend[c] = 1;
            start[c] = cyc;
         end
      end
   endtask

   function automatic logic [31:0] mv(int ch, int sel);
      if (sel > 6) return 32'd0;
      return 32'(m[ch][sel]);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(string tag, int ch, int sel, logic [31:0] exp);
      rd_v = 1'b1;
      rd_tlb = 1'(ch);
      rd_sel = 3'(sel);
      tick();
      rd_v = 1'b0;
      chk({tag, "_v"}, 32'(data_v), 32'd1);
      chk(tag, data, exp);
      data_yumi = 1'b1;
      tick();
      data_yumi = 1'b0;
      chk({tag, "_done"}, 32'(data_v), 32'd0);
   endtask

   task automatic rd_chk_s(string tag, int ch, logic [3:0] exp);
      rd_v_s = 1'b1;
      rd_tlb_s = 1'(ch);
      rd_sel_s = 3'd0;
      tick();
      rd_v_s = 1'b0;
      chk({tag, "_v"}, 32'(data_v_s), 32'd1);
      chk(tag, 32'(data_s), 32'(exp));
      yumi_s = 1'b1;
      tick();
      yumi_s = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      {freeze, clr_stats, rd_v, data_yumi, cam, miss, fill, clr_ch, rd_tlb, rd_sel} = '0;
      {freeze_s, clr_s, rd_v_s, yumi_s, cam_s, rd_tlb_s, rd_sel_s} = '0;
      model_clear();
      #1;
      chk("rst_data_v", 32'(data_v), 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_ready", 32'(rd_ready), 32'd1);
      reset_n = 1'b1;
      rd_chk("rst_reads", 0, 0, 32'd0);
      rd_chk("rst_latsum", 1, 4, 32'd0);
      // reset while a miss is outstanding
      miss[0] = 1'b1;
      tick();
      miss[0] = 1'b0;
      repeat (3) tick();
      #3 reset_n = 1'b0;
      model_clear();
      #1;
      chk("mid_rst_data_v", 32'(data_v), 32'd0);
      chk("mid_rst_ready", 32'(rd_ready), 32'd1);
      tick();
      reset_n = 1'b1;
      fill[0] = 1'b1;
      tick();
      fill[0] = 1'b0;
      rd_chk("mid_rst_latsum", 0, 4, 32'd0);
      rd_chk("mid_rst_misses", 0, 1, 32'd0);
      rd_chk("mid_rst_fills", 0, 2, 32'd1);
      // latency on channel 1
      pulse_clr();
      miss[1] = 1'b1;
      tick();
      miss[1] = 1'b0;
      repeat (4) tick();
      fill[1] = 1'b1;
      tick();
      fill[1] = 1'b0;
      rd_chk("lat5_sum", 1, 4, 32'd5);
      rd_chk("lat5_max", 1, 5, 32'd5);
      miss[1] = 1'b1;
      tick();
      miss[1] = 1'b0;
      tick();
      fill[1] = 1'b1;
      tick();
      fill[1] = 1'b0;
      rd_chk("lat2_sum", 1, 4, 32'd7);
      rd_chk("lat2_max", 1, 5, 32'd5);
      rd_chk("lat2_misses", 1, 1, 32'd2);
      rd_chk("lat2_fills", 1, 2, 32'd2);
      rd_chk("lat_ch0_quiet", 0, 4, 32'd0);
      // abort via flush
      pulse_clr();
      miss[0] = 1'b1;
      tick();
      miss[0] = 1'b0;
      tick();
      clr_ch[0] = 1'b1;
      tick();
      clr_ch[0] = 1'b0;
      fill[0] = 1'b1;
      tick();
      fill[0] = 1'b0;
      rd_chk("abort_cnt", 0, 6, 32'd1);
      rd_chk("abort_latsum", 0, 4, 32'd0);
      rd_chk("abort_fills", 0, 2, 32'd1);
      rd_chk("abort_clears", 0, 3, 32'd1);
      // same-cycle miss and fill stays idle
      pulse_clr();
      miss[0] = 1'b1;
      fill[0] = 1'b1;
      tick();
      {miss, fill} = '0;
      repeat (2) tick();
      fill[0] = 1'b1;
      tick();
      fill[0] = 1'b0;
      rd_chk("mf_misses", 0, 1, 32'd1);
      rd_chk("mf_fills", 0, 2, 32'd2);
      rd_chk("mf_latsum", 0, 4, 32'd0);
      rd_chk("mf_latmax", 0, 5, 32'd0);
      // readout backpressure
      rd_v = 1'b1;
      rd_tlb = 1'b0;
      rd_sel = 3'd1;
      tick();
      chk("bp_v", 32'(data_v), 32'd1);
      chk("bp_data", data, 32'd1);
      chk("bp_ready", 32'(rd_ready), 32'd0);
      rd_sel = 3'd7;
      for (int i = 0; i < 3; i++) begin
         clr_stats = (i == 1);
         tick();
         chk($sformatf("bp_hold%0d", i), data, 32'd1);
         chk($sformatf("bp_stall%0d", i), 32'(rd_ready), 32'd0);
      end
      clr_stats = 1'b0;
      data_yumi = 1'b1;
      #1;
      chk("bp_ready_yumi", 32'(rd_ready), 32'd1);
      tick();
      chk("bp_sel7_v", 32'(data_v), 32'd1);
      chk("bp_sel7", data, 32'd0);
      rd_v = 1'b0;
      tick();
      data_yumi = 1'b0;
      chk("bp_drain", 32'(data_v), 32'd0);
      rd_chk("bp_cleared", 0, 1, 32'd0);
      // freeze forces idle and blocks counting
      pulse_clr();
      freeze = 1'b1;
      miss[1] = 1'b1;
      cam = 2'b11;
      tick();
      {miss, cam} = '0;
      fill[1] = 1'b1;
      tick();
      fill[1] = 1'b0;
      freeze = 1'b0;
      rd_chk("frz_misses", 1, 1, 32'd0);
      rd_chk("frz_fills", 1, 2, 32'd0);
      rd_chk("frz_reads", 0, 0, 32'd0);
      miss[1] = 1'b1;
      tick();
      miss[1] = 1'b0;
      freeze = 1'b1;
      tick();
      freeze = 1'b0;
      fill[1] = 1'b1;
      tick();
      fill[1] = 1'b0;
      rd_chk("frz_wait_latsum", 1, 4, 32'd0);
      rd_chk("frz_wait_fills", 1, 2, 32'd1);
      // saturation on the narrow instance
      cam_s = 1'b1;
      repeat (20) tick();
      cam_s = 1'b0;
      rd_chk_s("sat_reads", 0, 4'd15);
      freeze_s = 1'b1;
      cam_s = 1'b1;
      repeat (5) tick();
      {freeze_s, cam_s} = '0;
      rd_chk_s("sat_frz_reads", 0, 4'd15);
      clr_s = 1'b1;
      tick();
      clr_s = 1'b0;
      cam_s = 1'b1;
      repeat (3) tick();
      freeze_s = 1'b1;
      repeat (5) tick();
      {freeze_s, cam_s} = '0;
      rd_chk_s("frz_reads3", 0, 4'd3);
      rd_chk_s("oob_tlb", 1, 4'd0);
      // random traffic against the model
      for (int it = 0; it < 300; it++) begin
         cam = 2'($urandom);
         miss = 2'($urandom & $urandom);
         fill = 2'($urandom & $urandom);
         clr_ch = 2'($urandom & $urandom & $urandom);
         freeze = ($urandom_range(15) == 0);
         clr_stats = ($urandom_range(99) == 0);
         tick();
         if (it % 30 == 29)
            for (int c = 0; c < n_lp; c++)
               for (int s = 0; s < 8; s++)
                  rd_chk($sformatf("rnd_c%0d_s%0d", c, s), c, s, mv(c, s));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
